// File: rtl/ps2_direction_rx.sv
// ps2_direction_rx: PS/2 deframer with E0/F0 prefix tracking and per-player direction state
module ps2_direction_rx #(
    parameter int NUM_PLAYERS = 2,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter logic [NUM_PLAYERS*36-1:0] KEYMAP = {9'h172, 9'h175, 9'h174, 9'h16B,
                                                   9'h01B, 9'h01D, 9'h023, 9'h01C}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_ps2_clk,
    input  logic                     i_ps2_dat,
    output logic [7:0]               o_code,
    output logic                     o_code_valid,
    output logic                     o_frame_err,
    output logic [4*NUM_PLAYERS-1:0] o_dir_held,
    output logic [4*NUM_PLAYERS-1:0] o_dir_last
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t r_state, w_state_n;
    logic [1:0] r_clk_s, r_dat_s;
    logic [FILTER_LEN-1:0] r_hist;
    logic r_fclk, r_fclk_d;
    logic [7:0] r_shift;
    logic [2:0] r_bitcnt;
    logic r_par;
    logic [TW-1:0] r_tcnt;
    logic r_ext, r_brk;
    logic w_dat, w_strobe, w_timeout, w_stop_ok, w_good, w_bad;
    logic [NUM_PLAYERS-1:0][3:0] w_m;
    logic [4*NUM_PLAYERS-1:0] w_held_n, w_last_n;

    assign w_dat = r_dat_s[1];
    assign w_strobe = r_fclk_d & ~r_fclk;
    assign w_timeout = r_state != IDLE && r_tcnt == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s <= '1;
            r_dat_s <= '1;
            r_hist <= '1;
            r_fclk <= 1'b1;
            r_fclk_d <= 1'b1;
        end else begin
            r_clk_s <= {r_clk_s[0], i_ps2_clk};
            r_dat_s <= {r_dat_s[0], i_ps2_dat};
            r_hist <= {r_hist[FILTER_LEN-2:0], r_clk_s[1]};
            r_fclk <= &r_hist ? 1'b1 : ~|r_hist ? 1'b0 : r_fclk;
            r_fclk_d <= r_fclk;
        end
    end

    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        if (w_timeout)
            w_state_n = IDLE;
        else if (w_strobe)
            case (r_state)
                IDLE:    w_state_n = w_dat ? IDLE : DATA;
                DATA:    w_state_n = r_bitcnt == 3'd7 ? PARITY : DATA;
                PARITY:  w_state_n = STOP;
                default: w_state_n = IDLE;
            endcase
    end

    // a timeout coinciding with the stop strobe reports an error, never a byte
    always_comb begin
        w_stop_ok = w_dat & (^r_shift ^ r_par);
        w_good = w_strobe & ~w_timeout & r_state == STOP & w_stop_ok;
        w_bad = w_timeout | (w_strobe & r_state == STOP & ~w_stop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_bitcnt <= '0;
            r_par <= 1'b0;
            r_tcnt <= '0;
            o_code <= '0;
            o_code_valid <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            r_tcnt <= (w_strobe || r_state == IDLE) ? '0 : r_tcnt + 1'b1;
            if (w_strobe && !w_timeout) begin
                r_bitcnt <= r_state == DATA ? r_bitcnt + 3'd1 : 3'd0;
                r_shift <= r_state == DATA ? {w_dat, r_shift[7:1]} : r_shift;
                r_par <= r_state == PARITY ? w_dat : r_par;
            end
            o_code_valid <= w_good;
            o_frame_err <= w_bad;
            o_code <= w_good ? r_shift : o_code;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_p
        for (genvar d = 0; d < 4; d++) begin : g_d
            assign w_m[p][d] = KEYMAP[36*p+9*d +: 9] == {r_ext, o_code};
        end
    end

    // make latches the lowest matching direction; break only clears last if it was that key
    always_comb begin
        w_held_n = o_dir_held;
        w_last_n = o_dir_last;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_held_n[4*p +: 4] = r_brk ? o_dir_held[4*p +: 4] & ~w_m[p] : o_dir_held[4*p +: 4] | w_m[p];
            w_last_n[4*p +: 4] = ~|w_m[p] ? o_dir_last[4*p +: 4] :
                                 !r_brk ? w_m[p] & (~w_m[p] + 4'd1) :
                                 |(o_dir_last[4*p +: 4] & w_m[p]) ? 4'd0 : o_dir_last[4*p +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
            o_dir_held <= '0;
            o_dir_last <= '0;
        end else if (o_code_valid) begin
            if (o_code == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (o_code == 8'hF0) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
                o_dir_held <= w_held_n;
                o_dir_last <= w_last_n;
            end
        end
    end
endmodule

// File: tb/tb_ps2_direction_rx.sv
// tb_ps2_direction_rx: randomized PS/2 frames checked against a key-event reference model
module tb_ps2_direction_rx;
    localparam int HALF = 20;
    localparam int TMO = 1000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    logic [7:0] code;
    logic code_valid, frame_err;
    logic [7:0] dir_held, dir_last;
    int total = 0;
    int bad = 0;
    int cv_cnt = 0;
    int err_cnt = 0;
    logic [7:0] cap_code = '0;
    int km [2][4] = '{'{'h01C, 'h023, 'h01D, 'h01B}, '{'h16B, 'h174, 'h175, 'h172}};
    logic [3:0] held_m [2];
    logic [3:0] last_m [2];
    logic ext_m, brk_m;
    logic [7:0] good_code;
    logic [7:0] pool [14] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h6B, 8'h74, 8'h75, 8'h72,
                              8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hAA, 8'hFA};

    ps2_direction_rx #(.NUM_PLAYERS(2), .FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat),
        .o_code(code), .o_code_valid(code_valid), .o_frame_err(frame_err),
        .o_dir_held(dir_held), .o_dir_last(dir_last)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (code_valid) begin
                cv_cnt++;
                cap_code = code;
            end
            if (frame_err) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        held_m = '{4'd0, 4'd0};
        last_m = '{4'd0, 4'd0};
        ext_m = 1'b0;
        brk_m = 1'b0;
        good_code = '0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit done;
        good_code = b;
        if (b == 8'hE0) ext_m = 1'b1;
        else if (b == 8'hF0) brk_m = 1'b1;
        else begin
            for (int p = 0; p < 2; p++) begin
                done = 0;
                for (int d = 0; d < 4; d++) begin
                    if (km[p][d] == int'({ext_m, b})) begin
                        if (!brk_m) begin
                            held_m[p][d] = 1'b1;
                            if (!done) last_m[p] = 4'b1 << d;
                            done = 1;
                        end else begin
                            held_m[p][d] = 1'b0;
                            if (last_m[p][d]) last_m[p] = 4'd0;
                        end
                    end
                end
            end
            ext_m = 1'b0;
            brk_m = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_dat = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_dirs(input string tag);
        check({tag, "_held"}, 32'(dir_held), 32'({held_m[1], held_m[0]}));
        check({tag, "_last"}, 32'(dir_last), 32'({last_m[1], last_m[0]}));
    endtask

    task automatic send_check(input logic [7:0] b, input logic badpar);
        int cv0, e0;
        cv0 = cv_cnt;
        e0 = err_cnt;
        send_bits({1'b1, ~^b ^ badpar, b, 1'b0}, 11);
        repeat (30) @(negedge clk);
        if (badpar) begin
            check("perr_pulse", 32'(err_cnt - e0), 32'd1);
            check("perr_nocv", 32'(cv_cnt - cv0), 32'd0);
        end else begin
            check("cv_pulse", 32'(cv_cnt - cv0), 32'd1);
            check("cv_code", 32'(cap_code), 32'(b));
            check("no_err", 32'(err_cnt - e0), 32'd0);
            model_byte(b);
        end
        check("code", 32'(code), 32'(good_code));
        check_dirs("dir");
    endtask

    initial begin
        int cv0, e0;
        logic [7:0] b;
        model_reset();
        do_reset();
        @(negedge clk);
        check("rst_code", 32'(code), 32'd0);
        check("rst_cv", 32'(code_valid), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check_dirs("rst");
        send_check(8'h1C, 1'b0);
        send_check(8'hF0, 1'b0);
        send_check(8'h1C, 1'b0);
        send_check(8'hE0, 1'b0);
        send_check(8'h75, 1'b0);
        send_check(8'h75, 1'b0);
        send_check(8'hE0, 1'b0);
        send_check(8'hF0, 1'b0);
        send_check(8'h75, 1'b0);
        send_check(8'h1D, 1'b1);
        send_check(8'h1D, 1'b0);
        cv0 = cv_cnt;
        e0 = err_cnt;
        send_bits(11'b00000_1010_0, 5);
        repeat (TMO + 60) @(negedge clk);
        check("tmo_err", 32'(err_cnt - e0), 32'd1);
        check("tmo_nocv", 32'(cv_cnt - cv0), 32'd0);
        check_dirs("tmo");
        send_check(8'h23, 1'b0);
        send_check(8'h1C, 1'b0);
        send_check(8'h23, 1'b0);
        send_check(8'hF0, 1'b0);
        send_check(8'h23, 1'b0);
        send_bits(11'b00000_0111_0, 4);
        do_reset();
        @(negedge clk);
        check("mrst_code", 32'(code), 32'd0);
        check_dirs("mrst");
        send_check(8'h1C, 1'b0);
        send_check(8'hE0, 1'b0);
        do_reset();
        send_check(8'h75, 1'b0);
        for (int i = 0; i < 70; i++) begin
            b = $urandom_range(0, 7) == 0 ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 13)];
            send_check(b, $urandom_range(0, 7) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
